// File: rtl/avg_seq_ctrl.sv
// Averager sequencer: reads N_PAIRS pilot pairs, then steers averager writes one cycle later.
// Optional abort input enabled by defining AVG_SEQ_CTRL_ABORT_EN.
module avg_seq_ctrl #(
  parameter int ADDR_W  = 3,
  parameter int N_PAIRS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef AVG_SEQ_CTRL_ABORT_EN
  input  logic              abort,
`endif
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic              avg_en,
  output logic [1:0]        avg_wr_addr,
  output logic              busy,
  output logic              done
);

  // state  | meaning
  // IDLE   | waiting for start, all outputs quiet
  // READ   | one pilot pair read per cycle, k = 0..N_PAIRS-1
  // DRAIN  | last averager write for pair N_PAIRS-1
  // DONE   | one-cycle done pulse, busy dropped
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(N_PAIRS - 1);
  localparam logic [ADDR_W-1:0] B_OFS  = ADDR_W'(N_PAIRS);
  localparam logic [ADDR_W-1:0] K_ONE  = ADDR_W'(1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] k, k_nxt;
  logic              rd_en_nxt, avg_en_nxt, busy_nxt, done_nxt;
  logic [ADDR_W-1:0] addr_a_nxt, addr_b_nxt;
  logic [1:0]        wr_addr_nxt;
  logic              abort_i;

`ifdef AVG_SEQ_CTRL_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    k_nxt       = k;
    rd_en_nxt   = 1'b0;
    addr_a_nxt  = '0;
    addr_b_nxt  = '0;
    busy_nxt    = 1'b0;
    done_nxt    = 1'b0;
    // averager side trails the read side by exactly one cycle
    avg_en_nxt  = rd_en;
    wr_addr_nxt = rd_en ? 2'(rd_addr_a) : 2'b00;

    case (state)
      S_IDLE: begin
        if (start && !abort_i) begin
          state_nxt = S_READ;
          k_nxt     = '0;
          rd_en_nxt = 1'b1;
          busy_nxt  = 1'b1;
        end
      end
      S_READ: begin
        if (abort_i) begin
          state_nxt   = S_IDLE;
          k_nxt       = '0;
          avg_en_nxt  = 1'b0;
          wr_addr_nxt = 2'b00;
        end else if (k == K_LAST) begin
          state_nxt = S_DRAIN;
          busy_nxt  = 1'b1;
        end else begin
          k_nxt     = k + K_ONE;
          rd_en_nxt = 1'b1;
          busy_nxt  = 1'b1;
        end
      end
      S_DRAIN: begin
        if (abort_i) begin
          state_nxt   = S_IDLE;
          avg_en_nxt  = 1'b0;
          wr_addr_nxt = 2'b00;
        end else begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
        end
        k_nxt = '0;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        k_nxt     = '0;
      end
    endcase

    if (rd_en_nxt) begin
      addr_a_nxt = k_nxt;
      addr_b_nxt = k_nxt + B_OFS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      k           <= '0;
      rd_en       <= 1'b0;
      rd_addr_a   <= '0;
      rd_addr_b   <= '0;
      avg_en      <= 1'b0;
      avg_wr_addr <= 2'b00;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      k           <= k_nxt;
      rd_en       <= rd_en_nxt;
      rd_addr_a   <= addr_a_nxt;
      rd_addr_b   <= addr_b_nxt;
      avg_en      <= avg_en_nxt;
      avg_wr_addr <= wr_addr_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
    end
  end

endmodule

// File: tb/tb_avg_seq_ctrl.sv
// Bench for avg_seq_ctrl: default instance (4 pairs) and a 2-pair instance, checked
// against a pass-offset reference model; abort scenario runs when AVG_SEQ_CTRL_ABORT_EN is set.
module tb_avg_seq_ctrl;
  logic clk = 1'b0;
  logic rst, start, start2;
`ifdef AVG_SEQ_CTRL_ABORT_EN
  logic abort;
`endif

  logic       rd_en1, avg_en1, busy1, done1;
  logic [2:0] a1, b1;
  logic [1:0] w1;
  logic       rd_en2, avg_en2, busy2, done2;
  logic [1:0] a2, b2;
  logic [1:0] w2;

  always #5 clk = ~clk;

  avg_seq_ctrl #(.ADDR_W(3), .N_PAIRS(4)) dut1 (
    .clk(clk), .rst(rst), .start(start),
`ifdef AVG_SEQ_CTRL_ABORT_EN
    .abort(abort),
`endif
    .rd_en(rd_en1), .rd_addr_a(a1), .rd_addr_b(b1),
    .avg_en(avg_en1), .avg_wr_addr(w1), .busy(busy1), .done(done1)
  );

  avg_seq_ctrl #(.ADDR_W(2), .N_PAIRS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2),
`ifdef AVG_SEQ_CTRL_ABORT_EN
    .abort(abort),
`endif
    .rd_en(rd_en2), .rd_addr_a(a2), .rd_addr_b(b2),
    .avg_en(avg_en2), .avg_wr_addr(w2), .busy(busy2), .done(done2)
  );

  logic [11:0] obs1, obs2, exp1, exp2;
  assign obs1 = {rd_en1, a1, b1, avg_en1, w1, busy1, done1};
  assign obs2 = {rd_en2, 1'b0, a2, 1'b0, b2, avg_en2, w2, busy2, done2};

  int cyc = 0;
  int ps1 = -1;
  int ps2 = -1;
  int n_checks = 0;
  int n_pass = 0;

  // Expected outputs from the offset d of the current cycle from the accepted start:
  // reads on d=1..n, averager writes on d=2..n+1, done on d=n+2.
  function automatic logic [11:0] model_out(input int n, input int aw, input int ps, input int c);
    int d;
    logic rd, ae, bz, dn;
    logic [2:0] a, b;
    logic [1:0] w;
    if (ps < 0) return 12'h000;
    d  = c - ps;
    rd = (d >= 1) && (d <= n);
    ae = (d >= 2) && (d <= n + 1);
    bz = (d >= 1) && (d <= n + 1);
    dn = (d == n + 2);
    a  = rd ? 3'(d - 1) : 3'd0;
    b  = rd ? 3'((d - 1 + n) % (1 << aw)) : 3'd0;
    w  = ae ? 2'(d - 2) : 2'd0;
    return {rd, a, b, ae, w, bz, dn};
  endfunction

  task automatic upd(inout int ps, input int n, input logic st, input logic rs, input logic ab);
    int d;
    d = (ps < 0) ? -1 : cyc - ps;
    if (rs) ps = -1;
    else if (ab && ps >= 0 && d >= 1 && d <= n + 1) ps = -1;
    else if (st && !ab && (ps < 0 || d >= n + 3)) ps = cyc;
  endtask

  task automatic tick(input logic st, input logic st2, input logic rs, input logic ab);
    start  = st;
    start2 = st2;
    rst    = rs;
`ifdef AVG_SEQ_CTRL_ABORT_EN
    abort  = ab;
`endif
    @(posedge clk);
    upd(ps1, 4, st, rs, ab);
    upd(ps2, 2, st2, rs, ab);
    cyc++;
    #1;
    exp1 = model_out(4, 3, ps1, cyc);
    exp2 = model_out(2, 2, ps2, cyc);
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (obs1 !== 12'h000) $display("FAIL reset_n4 got=%h want=000", obs1);
    else n_pass++;
    n_checks++;
    if (obs2 !== 12'h000) $display("FAIL reset_n2 got=%h want=000", obs2);
    else n_pass++;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_single_pass();
    int done_at1, done_at2, busy_cnt1;
    done_at1 = -1; done_at2 = -1; busy_cnt1 = 0;
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      n_checks++;
      if (obs1 !== exp1) $display("FAIL single_n4 cyc=%0d got=%h want=%h", i, obs1, exp1);
      else n_pass++;
      n_checks++;
      if (obs2 !== exp2) $display("FAIL single_n2 cyc=%0d got=%h want=%h", i, obs2, exp2);
      else n_pass++;
      if (done1 === 1'b1 && done_at1 < 0) done_at1 = i;
      if (done2 === 1'b1 && done_at2 < 0) done_at2 = i;
      if (busy1 === 1'b1) busy_cnt1++;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
    end
    n_checks++;
    if (done_at1 !== 6) $display("FAIL single_done_n4 got=%0d want=6", done_at1);
    else n_pass++;
    n_checks++;
    if (done_at2 !== 4) $display("FAIL single_done_n2 got=%0d want=4", done_at2);
    else n_pass++;
    n_checks++;
    if (busy_cnt1 !== 5) $display("FAIL single_busy_len got=%0d want=5", busy_cnt1);
    else n_pass++;
  endtask

  task automatic test_held_start();
    int passes1, passes2;
    logic prev1, prev2;
    passes1 = 0; passes2 = 0; prev1 = 1'b0; prev2 = 1'b0;
    for (int i = 0; i < 22; i++) begin
      tick(i < 10, i < 10, 1'b0, 1'b0);
      n_checks++;
      if (obs1 !== exp1) $display("FAIL held_n4 i=%0d got=%h want=%h", i, obs1, exp1);
      else n_pass++;
      n_checks++;
      if (obs2 !== exp2) $display("FAIL held_n2 i=%0d got=%h want=%h", i, obs2, exp2);
      else n_pass++;
      if (busy1 === 1'b1 && !prev1) passes1++;
      if (busy2 === 1'b1 && !prev2) passes2++;
      prev1 = busy1;
      prev2 = busy2;
    end
    n_checks++;
    if (passes1 !== 2) $display("FAIL held_passes_n4 got=%0d want=2", passes1);
    else n_pass++;
    n_checks++;
    if (passes2 !== 2) $display("FAIL held_passes_n2 got=%0d want=2", passes2);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int dones;
    dones = 0;
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (obs1 !== 12'h000) $display("FAIL rstmid_zero_n4 got=%h want=000", obs1);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      if (done1 === 1'b1) dones++;
    end
    n_checks++;
    if (dones !== 0) $display("FAIL rstmid_nodone got=%0d want=0", dones);
    else n_pass++;
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      n_checks++;
      if (obs1 !== exp1) $display("FAIL rstmid_rerun i=%0d got=%h want=%h", i, obs1, exp1);
      else n_pass++;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    int dcount, second_done;
    dcount = 0; second_done = -1;
    for (int i = 0; i <= 16; i++) begin
      tick(i == 0 || i == 6 || i == 7, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (obs1 !== exp1) $display("FAIL b2b_n4 cyc=%0d got=%h want=%h", i + 1, obs1, exp1);
      else n_pass++;
      if (done1 === 1'b1) begin
        dcount++;
        if (dcount == 2) second_done = i + 1;
      end
    end
    n_checks++;
    if (second_done !== 13) $display("FAIL b2b_second_done got=%0d want=13", second_done);
    else n_pass++;
  endtask

`ifdef AVG_SEQ_CTRL_ABORT_EN
  task automatic test_abort();
    int dones;
    dones = 0;
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if ({rd_en1, avg_en1, busy1} !== 3'b000) $display("FAIL abort_quiet got=%b want=000", {rd_en1, avg_en1, busy1});
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      if (done1 === 1'b1) dones++;
    end
    tick(1'b1, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (busy1 !== 1'b0 || dones !== 0) $display("FAIL abort_start got_busy=%b dones=%0d want=0", busy1, dones);
    else n_pass++;
  endtask
`endif

  task automatic test_random();
    logic ab;
    for (int i = 0; i < 600; i++) begin
      ab = 1'b0;
`ifdef AVG_SEQ_CTRL_ABORT_EN
      ab = ($urandom_range(0, 29) == 0);
`endif
      tick($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 49) == 0, ab);
      n_checks++;
      if (obs1 !== exp1) $display("FAIL rand_n4 cyc=%0d got=%h want=%h", cyc, obs1, exp1);
      else n_pass++;
      n_checks++;
      if (obs2 !== exp2) $display("FAIL rand_n2 cyc=%0d got=%h want=%h", cyc, obs2, exp2);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0;
`ifdef AVG_SEQ_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    test_reset();
    test_single_pass();
    test_held_start();
    test_reset_mid();
    test_back_to_back();
`ifdef AVG_SEQ_CTRL_ABORT_EN
    test_abort();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
